// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: valid/ready memory-mapped 8N1 UART transmitter with a circular TX FIFO.
// Defining MMIO_UART_TX_IRQ_EN builds the CTRL register and the drained interrupt.
module mmio_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  we_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic        req_q;
    logic [3:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  we_q;
    logic [31:0] rdata_q;
    logic        unused_addr;

    logic [15:0] div_q;
    logic [15:0] div_eff;
    logic [31:0] status;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_mux;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic [7:0]  push_byte;
    logic [7:0]  fifo_head;

    logic        is_txwr;
    logic        stall;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  shreg_q;
    logic [7:0]  shreg_d;
    logic [2:0]  bit_cnt_q;
    logic [2:0]  bit_cnt_d;
    logic [15:0] baud_q;
    logic [15:0] baud_d;
    logic        bit_done;
    logic        busy;

    assign unused_addr = ^addr_i[31:4];

    // Bus side: one request is captured, answered one cycle later, or held while
    // a TXDATA write waits for a FIFO slot.
    assign is_txwr = (addr_q[3:2] == 2'd0) && (we_q != 4'b0000);
    assign stall   = is_txwr && full && !pop;
    assign ready_o = req_q && !stall;
    assign push    = ready_o && is_txwr;
    assign rdata_o = ready_o ? rdata_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            rdata_q <= '0;
        end else if (ready_o) begin
            req_q <= 1'b0;
        end else if (!req_q && valid_i) begin
            req_q   <= 1'b1;
            addr_q  <= addr_i[3:0];
            wdata_q <= wdata_i;
            we_q    <= we_i;
            rdata_q <= (we_i == 4'b0000) ? rd_mux : '0;
        end
    end

    assign status = {16'b0, 8'(count), 5'b0, busy, full, empty};

    always_comb begin
        case (addr_i[3:2])
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {16'b0, div_q};
            2'd3:    rd_mux = ctrl_rd;
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    push_byte = wdata_q[7:0];
            2'd1:    push_byte = wdata_q[15:8];
            2'd2:    push_byte = wdata_q[23:16];
            default: push_byte = wdata_q[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DEFAULT_DIV;
        end else if (ready_o && addr_q[3:2] == 2'd2) begin
            if (we_q[0]) div_q[7:0]  <= wdata_q[7:0];
            if (we_q[1]) div_q[15:8] <= wdata_q[15:8];
        end
    end

    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

`ifdef MMIO_UART_TX_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
        end else if (ready_o && addr_q[3:2] == 2'd3 && we_q[0]) begin
            irq_en_q <= wdata_q[0];
        end
    end

    assign ctrl_rd = {31'b0, irq_en_q};
    assign irq_o   = irq_en_q && empty && !busy;
`else
    assign ctrl_rd = '0;
    assign irq_o   = 1'b0;
`endif

    // FIFO: pointers carry one extra wrap bit so full and empty differ.
    assign count     = wptr_q - rptr_q;
    assign empty     = (count == '0);
    assign full      = (count == FIFO_DEPTH[AW:0]);
    assign fifo_head = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= push_byte;
    end

    // Serializer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
        end
    end

    assign bit_done = (baud_q == 16'd0);

    // Every bit boundary reloads the baud counter from the live divisor; the end of
    // STOP pops directly into START so queued frames run back to back.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_d   = fifo_head;
                    bit_cnt_d = '0;
                    baud_d    = div_eff - 16'd1;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d  = div_eff - 16'd1;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d  = div_eff - 16'd1;
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                if (bit_done) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shreg_d   = fifo_head;
                        bit_cnt_d = '0;
                        baud_d    = div_eff - 16'd1;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        busy = 1'b1;
        case (state_q)
            IDLE:    busy = 1'b0;
            START:   tx_o = 1'b0;
            DATA:    tx_o = shreg_q[0];
            default: tx_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: bus responses and serial frames are queued by the
// stimulus and checked by independent monitors.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  we_i;
    logic [31:0] rdata_o;
    logic        tx_o;
    logic        irq_o;

    always #5 clk = ~clk;

    mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .we_i    (we_i),
        .rdata_o (rdata_o),
        .tx_o    (tx_o),
        .irq_o   (irq_o)
    );

    typedef struct { string name; logic [31:0] data; } rsp_t;
    typedef struct { logic [7:0] data; int unsigned div; } frame_t;

    rsp_t            rsp_q[$];
    frame_t          tx_q[$];
    longint unsigned start_q[$];
    longint unsigned cyc = 0;
    bit              in_frame = 1'b0;
    int unsigned     n_checks = 0;
    int unsigned     n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Bus monitor: each ready_o pulse consumes one expected response.
    logic prev_ready = 1'b0;
    always @(negedge clk) begin : bus_mon
        rsp_t r;
        if (ready_o) begin
            check("ready_single_cycle", {31'b0, prev_ready}, 32'd0);
            n_checks++;
            if (rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got ready_o=1 expected no response");
            end else begin
                r = rsp_q.pop_front();
                check(r.name, rdata_o, r.data);
            end
        end else begin
            check("rdata_idle_zero", rdata_o, 32'd0);
        end
        prev_ready = ready_o;
    end

    // Serial monitor: every falling edge on tx_o is matched against the next queued frame.
    initial begin : serial_mon
        frame_t      f;
        int unsigned bad;
        int unsigned seg;
        logic [7:0]  got;
        logic        exp_bit;
        logic        prev_tx;
        bit          aborted;
        bit          known;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev_tx && !tx_o) begin
                start_q.push_back(cyc);
                in_frame = 1'b1;
                bad = 0;
                got = '0;
                aborted = 1'b0;
                known = 1'b1;
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got start bit expected idle line");
                    known = 1'b0;
                    f.data = '0;
                    f.div = 1;
                end else begin
                    f = tx_q.pop_front();
                end
                for (int unsigned i = 0; i < 10 * f.div; i++) begin
                    if (i != 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    seg = i / f.div;
                    if (seg == 0) exp_bit = 1'b0;
                    else if (seg == 9) exp_bit = 1'b1;
                    else exp_bit = f.data[seg-1];
                    if (tx_o !== exp_bit) bad++;
                    if (seg >= 1 && seg <= 8 && (i % f.div) == f.div / 2) got[seg-1] = tx_o;
                end
                if (!aborted && known) begin
                    check("frame_byte", {24'b0, got}, {24'b0, f.data});
                    check("frame_waveform_bad_samples", bad, 32'd0);
                end
                in_frame = 1'b0;
                prev_tx = 1'b1;
            end else begin
                prev_tx = tx_o;
            end
        end
    end

    task automatic bus(input string name, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic [31:0] exp_rd, output int unsigned lat);
        rsp_t r;
        @(negedge clk);
        r.name = name;
        r.data = exp_rd;
        rsp_q.push_back(r);
        addr_i  = a;
        wdata_i = wd;
        we_i    = we;
        valid_i = 1'b1;
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready_o && lat < 5000);
        valid_i = 1'b0;
        we_i    = '0;
        if (!ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no ready_o after %0d cycles expected a response", name, lat);
            rsp_q.delete();
        end
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] we, input int unsigned exp_lat);
        int unsigned lat;
        bus(name, a, wd, we, 32'd0, lat);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        int unsigned lat;
        bus(name, a, 32'd0, 4'b0000, exp, lat);
        check({name, "_latency"}, lat, 32'd1);
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while ((tx_q.size() != 0 || in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, {31'b0, n < budget}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        frame_t f;
        logic [7:0] stall_bytes [10];
        stall_bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h7E, 8'h96};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        we_i    = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, ready_o}, 32'd0);
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_tx", {31'b0, tx_o}, 32'd1);
        check("reset_irq", {31'b0, irq_o}, 32'd0);
        rst_n = 1'b1;

        // Reset defaults and register map.
        rd("status_reset", 32'h4, 32'h0000_0001);
        check("tx_idle_high", {31'b0, tx_o}, 32'd1);
        rd("div_reset", 32'h8, 32'd434);
        rd("txdata_read_zero", 32'h0, 32'd0);
        rd("ctrl_reset", 32'hC, 32'd0);
        wr("status_write", 32'h4, 32'hFFFF_FFFF, 4'b1111, 1);
        rd("status_write_ignored", 32'h4, 32'h0000_0001);

        // Per-byte DIV enables: 0x01B2 -> 0x0104 -> 0x0004; upper address bits ignored.
        wr("div_lo", 32'hABCD_0008, 32'h0000_1204, 4'b0001, 1);
        rd("div_lo_rd", 32'h8, 32'h0000_0104);
        wr("div_hi", 32'h8, 32'hFFFF_0000, 4'b0010, 1);
        rd("div_hi_rd", 32'h8, 32'h0000_0004);

        // Single byte 0x41 from lane 3 at DIV=4; line falls two cycles after ready.
        f.data = 8'h41; f.div = 4; tx_q.push_back(f);
        wr("push_41", 32'h3, 32'h4100_0000, 4'b1000, 1);
        @(negedge clk);
        check("tx_high_n2", {31'b0, tx_o}, 32'd1);
        @(negedge clk);
        check("tx_low_n3", {31'b0, tx_o}, 32'd0);
        wait_drain("single", 200);

        // Back-to-back frames at DIV=2.
        wr("div2", 32'h8, 32'h0000_0002, 4'b0011, 1);
        start_q.delete();
        f.data = 8'h55; f.div = 2; tx_q.push_back(f);
        f.data = 8'hAA; f.div = 2; tx_q.push_back(f);
        wr("push_55", 32'h0, 32'h0000_0055, 4'b0001, 1);
        wr("push_aa", 32'h1, 32'h0000_AA00, 4'b0010, 1);
        rd("status_cnt1", 32'h4, 32'h0000_0104);
        repeat (20) @(negedge clk);
        rd("status_cnt0_busy", 32'h4, 32'h0000_0005);
        wait_drain("b2b", 200);
        rd("status_b2b_done", 32'h4, 32'h0000_0001);
        check("b2b_frame_count", start_q.size(), 32'd2);
        if (start_q.size() == 2) check("b2b_no_gap", 32'(start_q[1] - start_q[0]), 32'd20);

        // DIV=0 runs one clock per bit.
        wr("div0", 32'h8, 32'h0000_0000, 4'b0011, 1);
        rd("div0_rd", 32'h8, 32'h0000_0000);
        f.data = 8'hC3; f.div = 1; tx_q.push_back(f);
        wr("push_c3", 32'h2, 32'h00C3_0000, 4'b0100, 1);
        wait_drain("div0", 100);

        // Full stall at DIV=100: the serializer takes the first byte at once, so after
        // nine writes the FIFO holds eight and the tenth waits for the end of frame one.
        wr("div100", 32'h8, 32'h0000_0064, 4'b0011, 1);
        for (int k = 0; k < 9; k++) begin
            f.data = stall_bytes[k]; f.div = 100; tx_q.push_back(f);
            wr("push_fill", 32'h0, {24'b0, stall_bytes[k]}, 4'b0001, 1);
        end
        rd("status_full", 32'h4, 32'h0000_0806);
        f.data = stall_bytes[9]; f.div = 100; tx_q.push_back(f);
        wr("push_stalled", 32'h0, {24'b0, stall_bytes[9]}, 4'b0001, 982);
        rd("status_still_full", 32'h4, 32'h0000_0806);
        wait_drain("stall", 12000);
        rd("status_stall_done", 32'h4, 32'h0000_0001);

        // Interrupt on drain.
        wr("div2_irq", 32'h8, 32'h0000_0002, 4'b0011, 1);
        wr("ctrl_set", 32'hC, 32'h0000_0001, 4'b0001, 1);
`ifdef MMIO_UART_TX_IRQ_EN
        rd("ctrl_rd", 32'hC, 32'h0000_0001);
        check("irq_idle_high", {31'b0, irq_o}, 32'd1);
`else
        rd("ctrl_rd", 32'hC, 32'h0000_0000);
        check("irq_idle_tied", {31'b0, irq_o}, 32'd0);
`endif
        f.data = 8'h00; f.div = 2; tx_q.push_back(f);
        wr("push_00", 32'h0, 32'h0000_0000, 4'b0001, 1);
        @(negedge clk);
        check("irq_low_after_push", {31'b0, irq_o}, 32'd0);
        repeat (20) @(negedge clk);
        check("irq_low_last_stop", {31'b0, irq_o}, 32'd0);
        @(negedge clk);
`ifdef MMIO_UART_TX_IRQ_EN
        check("irq_rise_after_stop", {31'b0, irq_o}, 32'd1);
`else
        check("irq_stays_low", {31'b0, irq_o}, 32'd0);
`endif
        wait_drain("irq", 100);
        wr("ctrl_clr", 32'hC, 32'h0000_0000, 4'b0001, 1);
        check("irq_cleared", {31'b0, irq_o}, 32'd0);

        // Reset during DATA (bit 0 of 0x5A is low at that point).
        wr("div4_rst", 32'h8, 32'h0000_0004, 4'b0011, 1);
        f.data = 8'h5A; f.div = 4; tx_q.push_back(f);
        wr("push_5a", 32'h0, 32'h0000_005A, 4'b0001, 1);
        repeat (8) @(negedge clk);
        check("tx_data_bit0_low", {31'b0, tx_o}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("tx_high_on_reset", {31'b0, tx_o}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd("status_after_reset", 32'h4, 32'h0000_0001);
        rd("div_after_reset", 32'h8, 32'd434);
        check("tx_high_after_reset", {31'b0, tx_o}, 32'd1);

        repeat (5) @(negedge clk);
        check("frames_outstanding", tx_q.size(), 32'd0);
        check("responses_outstanding", rsp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
